// File: rtl/regfile_scanner_if.sv
// Stream/read-port bundle between regfile_scanner and its environment.
// The master side is the scanner; the slave side is the register file plus the consumer.
interface regfile_scanner_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_addr, last_addr, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_addr, busy, done
  );

  modport slave (
    output start, first_addr, last_addr, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_addr, busy, done
  );
endinterface

// File: rtl/regfile_scanner.sv
// Walks a latched address range over one combinational read port and streams each word with its address.
// Optional REGSCAN_SKIP_ZERO_EN: zero-valued registers are skipped instead of presented.
module regfile_scanner #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  regfile_scanner_if.master   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0] r_end, w_end_nxt;
  logic [ADDR_W-1:0] r_out_addr, w_out_addr_nxt;
  logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              w_last;
  logic              w_skip;

  assign w_last = (r_ptr == r_end);

`ifdef REGSCAN_SKIP_ZERO_EN
  assign w_skip = (bus.rd_data == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_end_nxt       = r_end;
    w_out_addr_nxt  = r_out_addr;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_ptr_nxt   = bus.first_addr;
          w_end_nxt   = bus.last_addr;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (w_skip) begin
          // Skipped word costs one cycle; the scan stays in FETCH unless it was the last address.
          if (w_last) w_state_nxt = DONE;
          else        w_ptr_nxt   = r_ptr + 1'b1;
        end else begin
          w_out_data_nxt  = bus.rd_data;
          w_out_addr_nxt  = r_ptr;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = HOLD;
        end
      end
      HOLD: begin
        if (r_out_valid && bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_ptr_nxt   = r_ptr + 1'b1;
            w_state_nxt = FETCH;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the output data/address registers are reset too, so a reset mid-scan leaves nothing stale on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_end       <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_end       <= w_end_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.rd_addr   = r_ptr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);

endmodule

// File: tb/tb_regfile_scanner.sv
// Scoreboard bench for regfile_scanner: directed scans push expected words, a negedge monitor pops and compares.
module tb_regfile_scanner;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } word_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] regs [16];
  word_t             sb [$];
  int                checks    = 0;
  int                failures  = 0;
  int                cyc       = 0;
  int                start_cyc = 0;

  regfile_scanner_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_scanner #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.rd_data = regs[bus.rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    sb.push_back('{addr: a, data: d});
  endtask

  // Monitor: a word is consumed at the rising edge following a negedge where valid && ready.
  always @(negedge clk) begin
    word_t w;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got addr %0h data %0h, expected no word", bus.out_addr, bus.out_data);
      end else begin
        w = sb.pop_front();
        check("word_addr", 32'(bus.out_addr), 32'(w.addr));
        check("word_data", 32'(bus.out_data), 32'(w.data));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_scan(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.first_addr = ~f;
    bus.last_addr  = ~l;
    start_cyc      = cyc;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("rd_addr_fetch", 32'(bus.rd_addr), 32'(f));
  endtask

  // Done must appear exp_lat edges after the start edge, for exactly one cycle.
  task automatic wait_done(input int exp_lat, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(found), 32'd1);
    if (found) begin
      check({name, "_done_latency"}, 32'(cyc - start_cyc), 32'(exp_lat));
      check({name, "_all_words"}, 32'(sb.size()), 32'd0);
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({name, "_idle_after"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int done_cnt;
    int valid_cnt;
    bit seen;
    for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rd_addr",   32'(bus.rd_addr),   32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_addr",  32'(bus.out_addr),  32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full scan 0..15: 16 words, done 32 edges after start.
    for (int i = 0; i < 16; i++) expect_word(4'(i), 16'h1000 + 16'(i));
    start_scan(4'd0, 4'd15);
    wait_done(32, "full");

    // Wrap-around 14..1.
    expect_word(4'd14, 16'h100E);
    expect_word(4'd15, 16'h100F);
    expect_word(4'd0,  16'h1000);
    expect_word(4'd1,  16'h1001);
    start_scan(4'd14, 4'd1);
    wait_done(8, "wrap");

    // Single word.
    expect_word(4'd7, 16'h1007);
    start_scan(4'd7, 4'd7);
    wait_done(2, "single");

    // Backpressure on the third word, with an ignored start pulse.
    for (int i = 0; i < 6; i++) expect_word(4'(i), 16'h1000 + 16'(i));
    start_scan(4'd0, 4'd5);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid && bus.out_addr == 4'd1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bp_reach_word1", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready  = 1'b0;
    bus.start      = 1'b1;
    bus.first_addr = 4'd9;
    bus.last_addr  = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_addr",  32'(bus.out_addr),  32'd2);
      check("bp_data",  32'(bus.out_data),  32'h1002);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_done(17, "bp");

    // Zero-valued register: presented by default, skipped with the option.
    regs[3] = 16'h0000;
    regs[4] = 16'hBEEF;
`ifdef REGSCAN_SKIP_ZERO_EN
    expect_word(4'd4, 16'hBEEF);
    start_scan(4'd3, 4'd4);
    wait_done(3, "zero");
`else
    expect_word(4'd3, 16'h0000);
    expect_word(4'd4, 16'hBEEF);
    start_scan(4'd3, 4'd4);
    wait_done(4, "zero");
`endif

    // Asynchronous reset while in HOLD abandons the scan.
    bus.out_ready = 1'b0;
    start_scan(4'd0, 4'd15);
    @(negedge clk);
    check("hold_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rd_addr",   32'(bus.rd_addr),   32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data",  32'(bus.out_data),  32'd0);
    check("arst_out_addr",  32'(bus.out_addr),  32'd0);
    check("arst_busy",      32'(bus.busy),      32'd0);
    check("arst_done",      32'(bus.done),      32'd0);
    repeat (2) @(negedge clk);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    done_cnt  = 0;
    valid_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done)      done_cnt++;
      if (bus.out_valid) valid_cnt++;
    end
    check("arst_no_done",  32'(done_cnt),  32'd0);
    check("arst_no_valid", 32'(valid_cnt), 32'd0);
    check("arst_idle",     32'(bus.busy),  32'd0);

    // A fresh scan works after the abandoned one.
    expect_word(4'd5, 16'h1005);
    start_scan(4'd5, 4'd5);
    wait_done(2, "post_rst");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
